// File: rtl/term_loop_tile.sv
// Terminating tile: loops END back to BEG under configuration control and
// runs an LFSR round-trip self-test through the fabric wires.
module term_loop_tile #(
    parameter int WIRES           = 8,
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int CFG_FRAME       = 0,
    parameter int LAT             = 2
) (
    input  logic                       UserCLK,
    input  logic                       UserRST,
    output logic                       UserCLKo,
    input  logic [FrameBitsPerRow-1:0] FrameData,
    output logic [FrameBitsPerRow-1:0] FrameData_O,
    input  logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic [MaxFramesPerCol-1:0] FrameStrobe_O,
    input  logic [WIRES-1:0]           END,
    output logic [WIRES-1:0]           BEG,
    output logic                       TestBusy,
    output logic                       TestDone,
    output logic                       TestFail,
    output logic [7:0]                 ErrCount
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [15:0] SEED = 16'hACE1;

    // Behavioural stand-ins for the fabric's clock and data buffers.
    assign UserCLKo      = UserCLK;
    assign FrameData_O   = FrameData;
    assign FrameStrobe_O = FrameStrobe;

    logic [FrameBitsPerRow-1:0] cfg_q;
    logic                       start_prev_q;
    logic [1:0]                 state_q, state_d;
    logic [7:0]                 cnt_q, cnt_d;
    logic [15:0]                lfsr_q, lfsr_d;
    logic [7:0]                 err_q, err_d;
    logic [WIRES-1:0]           beg_test_q, beg_test_d;
    logic [WIRES-1:0]           loop_q;
    logic [LAT-1:0]             dl_vld_q;
    logic [WIRES-1:0]           dl_pat_q [LAT];
    logic                       clr_vld;

    logic       cfg_en, cfg_reg, cfg_start, cfg_inv;
    logic [7:0] cfg_len;
    logic       start_rise, busy, mismatch;
    logic       unused_cfg;

    assign cfg_en     = cfg_q[0];
    assign cfg_reg    = cfg_q[1];
    assign cfg_start  = cfg_q[2];
    assign cfg_inv    = cfg_q[3];
    assign cfg_len    = cfg_q[15:8];
    assign unused_cfg = ^{cfg_q[7:4], cfg_q[FrameBitsPerRow-1:16]};

    assign start_rise = cfg_start & ~start_prev_q;
    assign busy       = (state_q == S_DRIVE) || (state_q == S_FLUSH);
    assign mismatch   = busy && dl_vld_q[LAT-1] && (END != dl_pat_q[LAT-1]);

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lfsr_d     = lfsr_q;
        err_d      = err_q;
        beg_test_d = '0;
        clr_vld    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cfg_en && start_rise) begin
                    state_d    = S_DRIVE;
                    cnt_d      = cfg_len - 8'd1;  // LEN=0 wraps to 255, i.e. 256 cycles
                    lfsr_d     = lfsr_step(SEED);
                    beg_test_d = SEED[WIRES-1:0];
                    err_d      = '0;
                end
            end
            S_DRIVE: begin
                if (!cfg_en) begin
                    state_d = S_IDLE;
                    clr_vld = 1'b1;
                end else begin
                    lfsr_d = lfsr_step(lfsr_q);
                    if (cnt_q == 8'd0) begin
                        state_d = S_FLUSH;
                        cnt_d   = 8'(LAT - 1);
                    end else begin
                        cnt_d      = cnt_q - 8'd1;
                        beg_test_d = lfsr_q[WIRES-1:0];
                    end
                end
            end
            S_FLUSH: begin
                if (!cfg_en) begin
                    state_d = S_IDLE;
                    clr_vld = 1'b1;
                end else if (cnt_q == 8'd0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                if (!cfg_start) state_d = S_IDLE;
            end
        endcase
        if (mismatch && (err_q != 8'hFF)) err_d = err_q + 8'd1;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge UserCLK) begin
        if (UserRST) begin
            cfg_q        <= '0;
            start_prev_q <= 1'b0;
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            lfsr_q       <= SEED;
            err_q        <= '0;
            beg_test_q   <= '0;
            loop_q       <= '0;
            dl_vld_q     <= '0;
        end else begin
            if (FrameStrobe[CFG_FRAME]) cfg_q <= FrameData;
            start_prev_q <= cfg_start;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lfsr_q       <= lfsr_d;
            err_q        <= err_d;
            beg_test_q   <= beg_test_d;
            loop_q       <= END ^ {WIRES{cfg_inv}};
            if (clr_vld) begin
                dl_vld_q <= '0;
            end else begin
                dl_vld_q[0] <= (state_q == S_DRIVE);
                for (int i = 1; i < LAT; i++) dl_vld_q[i] <= dl_vld_q[i-1];
            end
        end
    end

    // NOTE: the pattern store has no reset; its contents are only observed
    // behind a valid bit, and the valids are reset.
    always_ff @(posedge UserCLK) begin
        dl_pat_q[0] <= beg_test_q;
        for (int i = 1; i < LAT; i++) dl_pat_q[i] <= dl_pat_q[i-1];
    end

    always_comb begin
        if (busy)          BEG = beg_test_q;
        else if (!cfg_en)  BEG = '0;
        else if (cfg_reg)  BEG = loop_q;
        else               BEG = END ^ {WIRES{cfg_inv}};
    end

    assign TestBusy = busy;
    assign TestDone = (state_q == S_DONE);
    assign TestFail = TestDone && (err_q != 8'd0);
    assign ErrCount = err_q;

endmodule

// File: tb/tb_term_loop_tile.sv
// Directed bench for term_loop_tile: loop modes checked inline, self-test
// results checked by a monitor against a scoreboard of expected outcomes.
module tb_term_loop_tile;

    localparam int WIRES = 8;
    localparam int MFPC  = 20;
    localparam int FBPR  = 32;
    localparam int CFGF  = 0;
    localparam int LAT   = 2;

    logic              UserCLK = 1'b0;
    logic              UserRST;
    logic              UserCLKo;
    logic [FBPR-1:0]   FrameData;
    logic [FBPR-1:0]   FrameData_O;
    logic [MFPC-1:0]   FrameStrobe;
    logic [MFPC-1:0]   FrameStrobe_O;
    logic [WIRES-1:0]  END;
    logic [WIRES-1:0]  BEG;
    logic              TestBusy, TestDone, TestFail;
    logic [7:0]        ErrCount;

    term_loop_tile #(
        .WIRES(WIRES), .MaxFramesPerCol(MFPC), .FrameBitsPerRow(FBPR),
        .CFG_FRAME(CFGF), .LAT(LAT)
    ) dut (
        .UserCLK(UserCLK), .UserRST(UserRST), .UserCLKo(UserCLKo),
        .FrameData(FrameData), .FrameData_O(FrameData_O),
        .FrameStrobe(FrameStrobe), .FrameStrobe_O(FrameStrobe_O),
        .END(END), .BEG(BEG),
        .TestBusy(TestBusy), .TestDone(TestDone), .TestFail(TestFail),
        .ErrCount(ErrCount)
    );

    always #5 UserCLK = ~UserCLK;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Fabric model: 0 = bench-driven, 1 = BEG delayed 2, 2 = same with bit 3 stuck-at-0, 3 = inverted.
    int               lb_mode = 0;
    logic [WIRES-1:0] end_drv = '0;
    logic [WIRES-1:0] bh1 = '0, bh2 = '0;

    always @(posedge UserCLK) begin
        bh1 <= BEG;
        bh2 <= bh1;
    end

    assign END = (lb_mode == 0) ? end_drv :
                 (lb_mode == 1) ? bh2 :
                 (lb_mode == 2) ? (bh2 & 8'hF7) : ~bh2;

    typedef struct {
        string      name;
        int         busy;
        logic [7:0] err;
        logic       fail;
    } result_t;

    result_t          exp_q[$];
    logic [WIRES-1:0] beg_exp_q[$];

    initial begin : monitor
        int   busy_cnt;
        logic prev_busy;
        logic prev_done;
        busy_cnt  = 0;
        prev_busy = 1'b0;
        prev_done = 1'b0;
        forever begin
            @(negedge UserCLK);
            if (UserRST === 1'b1) begin
                busy_cnt  = 0;
                prev_busy = 1'b0;
                prev_done = 1'b0;
            end else begin
                if (TestBusy === 1'b1) begin
                    busy_cnt++;
                    if (beg_exp_q.size() > 0) check("beg_pattern", 32'(BEG), 32'(beg_exp_q.pop_front()));
                end
                if (TestDone === 1'b1 && !prev_done) begin
                    if (exp_q.size() == 0) begin
                        check("sb_underflow", exp_q.size(), 1);
                    end else begin
                        result_t e;
                        e = exp_q.pop_front();
                        check({e.name, "_busy_cycles"}, busy_cnt, e.busy);
                        check({e.name, "_errcount"}, 32'(ErrCount), 32'(e.err));
                        check({e.name, "_testfail"}, 32'(TestFail), 32'(e.fail));
                    end
                    busy_cnt = 0;
                end else if (prev_busy && TestBusy !== 1'b1) begin
                    busy_cnt = 0;
                end
                prev_busy = (TestBusy === 1'b1);
                prev_done = (TestDone === 1'b1);
            end
        end
    end

    task automatic wr_cfg(input logic [15:0] v);
        @(negedge UserCLK);
        FrameData   = {16'hDEAD, v};
        FrameStrobe = MFPC'(1) << CFGF;
        @(negedge UserCLK);
        FrameStrobe = '0;
    endtask

    task automatic wait_done(input int max_cycles);
        int n = 0;
        while (TestDone !== 1'b1 && n < max_cycles) begin
            @(negedge UserCLK);
            n++;
        end
        if (TestDone !== 1'b1) check("timeout_done", 32'(TestDone), 1);
    endtask

    task automatic wait_busy(input int max_cycles);
        int n = 0;
        while (TestBusy !== 1'b1 && n < max_cycles) begin
            @(negedge UserCLK);
            n++;
        end
        if (TestBusy !== 1'b1) check("timeout_busy", 32'(TestBusy), 1);
    endtask

    initial begin
        UserRST     = 1'b1;
        FrameData   = 32'h1234_5678;
        FrameStrobe = '0;
        repeat (3) @(negedge UserCLK);
        check("rst_beg", 32'(BEG), 0);
        check("rst_busy", 32'(TestBusy), 0);
        check("rst_done", 32'(TestDone), 0);
        check("rst_fail", 32'(TestFail), 0);
        check("rst_err", 32'(ErrCount), 0);
        check("rst_framedata_pass", FrameData_O, 32'h1234_5678);
        check("clk_pass_lo", 32'(UserCLKo), 0);
        UserRST = 1'b0;
        @(posedge UserCLK); #1;
        check("clk_pass_hi", 32'(UserCLKo), 1);

        // Combinational loop, then a strobe on a foreign frame bit must not load CFG.
        lb_mode = 0;
        wr_cfg(16'h0001);
        end_drv = 8'hA5; #1;
        check("loop_comb_a5", 32'(BEG), 32'hA5);
        end_drv = 8'h3C; #1;
        check("loop_comb_3c", 32'(BEG), 32'h3C);
        @(negedge UserCLK);
        FrameData   = 32'h0;
        FrameStrobe = 20'h00002;
        #1;
        check("strobe_pass", 32'(FrameStrobe_O), 32'h00002);
        @(negedge UserCLK);
        FrameStrobe = '0;
        end_drv = 8'hA5; #1;
        check("foreign_strobe_ignored", 32'(BEG), 32'hA5);

        // Registered, inverted loop: one cycle of latency.
        wr_cfg(16'h000B);
        end_drv = 8'h0F;
        @(negedge UserCLK);
        check("loop_reg_settle", 32'(BEG), 32'hF0);
        end_drv = 8'hA5; #1;
        check("loop_reg_hold", 32'(BEG), 32'hF0);
        @(negedge UserCLK);
        check("loop_reg_5a", 32'(BEG), 32'h5A);

        // START already high when EN rises must not launch a test.
        wr_cfg(16'h0404); #1;
        check("en0_beg_zero", 32'(BEG), 0);
        wr_cfg(16'h0405);
        repeat (3) @(negedge UserCLK);
        check("no_start_on_en_rise", 32'(TestBusy), 0);
        wr_cfg(16'h0401);

        // Clean loopback, LEN=4: first patterns E1 70 38 9C, then two zero flush cycles.
        lb_mode = 1;
        beg_exp_q.push_back(8'hE1);
        beg_exp_q.push_back(8'h70);
        beg_exp_q.push_back(8'h38);
        beg_exp_q.push_back(8'h9C);
        beg_exp_q.push_back(8'h00);
        beg_exp_q.push_back(8'h00);
        exp_q.push_back('{name: "loop_ok", busy: 6, err: 8'd0, fail: 1'b0});
        wr_cfg(16'h0405);
        wait_done(40);

        // Rewriting START=1 while still 1 must not restart.
        wr_cfg(16'h0405);
        repeat (3) @(negedge UserCLK);
        check("no_restart_done", 32'(TestDone), 1);
        check("no_restart_busy", 32'(TestBusy), 0);
        wr_cfg(16'h0401);
        @(negedge UserCLK);
        check("done_to_idle", 32'(TestDone), 0);

        // Bit 3 stuck-at-0: patterns 38 and 9C carry bit 3.
        lb_mode = 2;
        exp_q.push_back('{name: "stuck_bit3", busy: 6, err: 8'd2, fail: 1'b1});
        wr_cfg(16'h0405);
        wait_done(40);
        wr_cfg(16'h0401);
        @(negedge UserCLK);
        check("err_hold_idle", 32'(ErrCount), 2);
        check("fail_drops_idle", 32'(TestFail), 0);

        // A fresh test clears the previous error count.
        lb_mode = 1;
        exp_q.push_back('{name: "restart_clear", busy: 6, err: 8'd0, fail: 1'b0});
        wr_cfg(16'h0405);
        wait_done(40);
        wr_cfg(16'h0401);
        @(negedge UserCLK);

        // LEN=0 means 256 drive cycles; every slot mismatches.
        lb_mode = 3;
        exp_q.push_back('{name: "saturate", busy: 258, err: 8'd255, fail: 1'b1});
        wr_cfg(16'h0005);
        wait_done(400);
        wr_cfg(16'h0001);
        @(negedge UserCLK);

        // Abort mid-DRIVE: six compares land before the FSM leaves DRIVE.
        wr_cfg(16'h0005);
        wait_busy(10);
        repeat (5) @(negedge UserCLK);
        wr_cfg(16'h0000);
        check("abort_cycle_busy", 32'(TestBusy), 1);
        @(negedge UserCLK);
        check("abort_busy", 32'(TestBusy), 0);
        check("abort_done", 32'(TestDone), 0);
        check("abort_beg", 32'(BEG), 0);
        check("abort_err", 32'(ErrCount), 6);
        repeat (3) @(negedge UserCLK);
        check("abort_err_hold", 32'(ErrCount), 6);

        // Reset during the first FLUSH cycle.
        lb_mode = 1;
        wr_cfg(16'h0405);
        wait_busy(10);
        repeat (4) @(negedge UserCLK);
        check("in_flush_beg_zero", 32'(BEG), 0);
        UserRST = 1'b1;
        @(negedge UserCLK);
        check("midrst_busy", 32'(TestBusy), 0);
        check("midrst_done", 32'(TestDone), 0);
        check("midrst_fail", 32'(TestFail), 0);
        check("midrst_err", 32'(ErrCount), 0);
        check("midrst_beg", 32'(BEG), 0);
        check("midrst_framedata_pass", FrameData_O, 32'hDEAD_0405);
        UserRST = 1'b0;
        lb_mode = 0;
        end_drv = 8'hA5;
        @(negedge UserCLK);
        check("midrst_cfg_cleared", 32'(BEG), 0);

        repeat (2) @(negedge UserCLK);
        check("scoreboard_drained", exp_q.size(), 0);
        check("beg_queue_drained", beg_exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/term_loop_tile.md
TERM_LOOP_TILE -- requirements
Module: term_loop_tile

Interface
REQ-001 SHALL have parameter WIRES, default 8, meaning number of terminated wires looped END->BEG (legal 1..16).
REQ-002 SHALL have parameter MaxFramesPerCol, default 20, meaning frame strobe width.
REQ-003 SHALL have parameter FrameBitsPerRow, default 32, meaning frame data width (legal >=16).
REQ-004 SHALL have parameter CFG_FRAME, default 0, meaning the FrameStrobe bit that loads this tile's config word.
REQ-005 SHALL have parameter LAT, default 2, meaning fabric round-trip latency in cycles for self-test compare (legal 1..8).
REQ-006 UserCLK  input  1  sole clock, rising edge.
REQ-007 UserRST  input  1  reset; one clock, reset is synchronous and active-high.
REQ-008 UserCLKo  output  1  UserCLK passed through via clock buffer.
REQ-009 FrameData  input  FrameBitsPerRow  configuration frame data.
REQ-010 FrameData_O  output  FrameBitsPerRow  FrameData passed through via buffer.
REQ-011 FrameStrobe  input  MaxFramesPerCol  frame strobes.
REQ-012 FrameStrobe_O  output  MaxFramesPerCol  FrameStrobe passed through via buffer.
REQ-013 END  input  WIRES  incoming wires from the fabric.
REQ-014 BEG  output  WIRES  outgoing wires back into the fabric.
REQ-015 TestBusy  output  1  self-test running.
REQ-016 TestDone  output  1  self-test finished, result valid.
REQ-017 TestFail  output  1  finished with at least one mismatch.
REQ-018 ErrCount  output  8  saturating mismatch-cycle count.

Function
REQ-019 CFG register (FrameBitsPerRow bits) SHALL load FrameData on any rising edge where FrameStrobe[CFG_FRAME]=1.
REQ-020 Fields: CFG[0]=EN, CFG[1]=REG, CFG[2]=START, CFG[3]=INV, CFG[15:8]=LEN (0 means 256); other bits ignored.
REQ-021 Loop mode (FSM IDLE/DONE): EN=0 -> BEG=0; EN=1,REG=0 -> BEG=END^{WIRES{INV}} combinationally; EN=1,REG=1 -> same value registered, latency exactly 1 cycle.
REQ-022 Self-test FSM states IDLE, DRIVE, FLUSH, DONE.
REQ-023 IDLE->DRIVE on cycle START rises 0->1 (edge detect on registered START) while EN=1; START already 1 at EN rise SHALL not trigger.
REQ-024 Entering DRIVE SHALL clear ErrCount and load LFSR seed 16'hACE1.
REQ-025 LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every DRIVE cycle; BEG = LFSR[WIRES-1:0] registered (INV, REG ignored during test).
REQ-026 DRIVE SHALL last exactly LEN cycles, then FLUSH for exactly LAT cycles with BEG=0, then DONE.
REQ-027 Each driven pattern plus valid bit SHALL enter a LAT-deep delay line; when the valid bit emerges, END != delayed pattern SHALL increment ErrCount, saturating at 255.
REQ-028 Compare SHALL run in DRIVE and FLUSH only; invalid (bubble) slots never counted.
REQ-029 TestBusy=1 in DRIVE/FLUSH; TestDone=1 in DONE; TestFail=TestDone&(ErrCount!=0).
REQ-030 DONE->IDLE when START=0; ErrCount holds until next DRIVE entry.
REQ-031 EN=0 written during DRIVE/FLUSH SHALL abort to IDLE next cycle: TestBusy=0, TestDone=0, ErrCount held, delay line valids cleared.
REQ-032 Config write and FSM transition in same cycle: FSM acts on CFG value before the write.

Reset
REQ-033 UserRST=1 on a rising edge SHALL set CFG=0, FSM=IDLE, LFSR=16'hACE1, delay line valids=0, ErrCount=0, BEG=0, TestBusy=TestDone=TestFail=0, including mid-test; pass-through outputs unaffected.

Verification
REQ-034 Write CFG=0x0001, END=0xA5 -> BEG=0xA5 same cycle; CFG=0x000B -> BEG=0x5A one cycle after END change.
REQ-035 CFG=0x0405 with END tied to BEG delayed 2 cycles -> TestBusy 6 cycles, TestDone=1, ErrCount=0, TestFail=0.
REQ-036 Same with END bit 3 stuck-at-0 -> TestFail=1, ErrCount equals count of 4 expected patterns with bit 3=1.
REQ-037 LEN=0, forced mismatch every cycle -> 258 cycles busy, ErrCount saturates at 255.
REQ-038 Write CFG=0x0000 mid-DRIVE -> IDLE next cycle, TestDone=0, BEG=0; UserRST mid-FLUSH -> all REQ-033 values next cycle.
REQ-039 START held 1 through DONE then rewritten 1 -> no restart; cleared then set -> new test, ErrCount cleared.
